wb_mem_responder: RTL and testbench

Wishbone responder that terminates both buses driven by the three-CPU arbiter: a read/write data port (`wb_cyc/wb_stb/wb_we/wb_adr/wb_dat_i` → `wb_ack/wb_dat_o`) and a read-only instruction port (`wb_inst_cyc/wb_inst_stb/wb_inst_pc` → `wb_inst_ack/wb_inst_o`). Both ports share one true-dual-port word memory and are served concurrently. Each port has its own handshake FSM with a programmable wait-state count. It sits directly below the arbiter as the shared data/instruction store.

---
 rtl/wb_mem_responder.sv | 151 +++++++++++++++
 tb/tb_wb_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_responder.sv
// Dual-port Wishbone memory responder: data port (read/write) and instruction port (read-only).
// Define WB_RESP_ERR_EN to add wb_err, flagging addresses with bits above ADDR_W-1 set.
module wb_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 16,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] wb_adr,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack,
  input  logic              wb_inst_cyc,
  input  logic              wb_inst_stb,
  input  logic [PC_W-1:0]   wb_inst_pc,
  output logic [DATA_W-1:0] wb_inst_o,
  output logic              wb_inst_ack
`ifdef WB_RESP_ERR_EN
  ,
  output logic              wb_err
`endif
);

`ifdef WB_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // ---------------- data port ----------------
  state_t            d_state, d_next;
  logic [3:0]        d_cnt;
  logic [ADDR_W-1:0] d_idx, d_rd_idx;
  logic              d_we, d_err, d_req, d_oor, d_we_now, d_err_now;
  logic [DATA_W-1:0] d_wdat, d_rdat;

  assign d_req     = wb_cyc & wb_stb;
  assign d_oor     = |wb_adr[DATA_W-1:ADDR_W];
  // With zero wait states ACK is entered straight from IDLE, so read from the live bus.
  assign d_rd_idx  = (d_state == IDLE) ? wb_adr[ADDR_W-1:0] : d_idx;
  assign d_we_now  = (d_state == IDLE) ? wb_we : d_we;
  assign d_err_now = (d_state == IDLE) ? (ERR_EN & d_oor) : d_err;

  always_comb begin
    d_next = d_state;
    case (d_state)
      IDLE:    if (d_req) d_next = (WS != 4'd0) ? WAIT : ACK;
      WAIT: begin
        if (!wb_cyc)             d_next = IDLE;
        else if (d_cnt == 4'd1)  d_next = ACK;
      end
      ACK:     d_next = IDLE;
      default: d_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_state <= IDLE;
      d_cnt   <= '0;
      d_idx   <= '0;
      d_we    <= 1'b0;
      d_err   <= 1'b0;
      d_wdat  <= '0;
      d_rdat  <= '0;
    end else begin
      d_state <= d_next;
      if (d_state == IDLE && d_req) begin
        d_cnt  <= WS;
        d_idx  <= wb_adr[ADDR_W-1:0];
        d_we   <= wb_we;
        d_wdat <= wb_dat_i;
        d_err  <= ERR_EN & d_oor;
      end else if (d_state == WAIT) begin
        d_cnt <= d_cnt - 4'd1;
      end
      d_rdat <= (d_next == ACK && !d_we_now && !d_err_now) ? mem[d_rd_idx] : '0;
    end
  end

  // ---------------- instruction port ----------------
  state_t            i_state, i_next;
  logic [3:0]        i_cnt;
  logic [ADDR_W-1:0] i_idx, i_rd_idx;
  logic              i_err, i_req, i_oor, i_err_now;
  logic [DATA_W-1:0] i_rdat;

  assign i_req     = wb_inst_cyc & wb_inst_stb;
  assign i_oor     = |wb_inst_pc[PC_W-1:ADDR_W];
  assign i_rd_idx  = (i_state == IDLE) ? wb_inst_pc[ADDR_W-1:0] : i_idx;
  assign i_err_now = (i_state == IDLE) ? (ERR_EN & i_oor) : i_err;

  always_comb begin
    i_next = i_state;
    case (i_state)
      IDLE:    if (i_req) i_next = (WS != 4'd0) ? WAIT : ACK;
      WAIT: begin
        if (!wb_inst_cyc)        i_next = IDLE;
        else if (i_cnt == 4'd1)  i_next = ACK;
      end
      ACK:     i_next = IDLE;
      default: i_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_state <= IDLE;
      i_cnt   <= '0;
      i_idx   <= '0;
      i_err   <= 1'b0;
      i_rdat  <= '0;
    end else begin
      i_state <= i_next;
      if (i_state == IDLE && i_req) begin
        i_cnt <= WS;
        i_idx <= wb_inst_pc[ADDR_W-1:0];
        i_err <= ERR_EN & i_oor;
      end else if (i_state == WAIT) begin
        i_cnt <= i_cnt - 4'd1;
      end
      // Non-blocking read sees the pre-write word when a data write commits on the same edge.
      i_rdat <= (i_next == ACK && !i_err_now) ? mem[i_rd_idx] : '0;
    end
  end

  // Write commits at the edge closing the ACK cycle; reset forces IDLE, cancelling it.
  always_ff @(posedge clk) begin
    if (d_state == ACK && d_we && !d_err)
      mem[d_idx] <= d_wdat;
  end

  assign wb_ack      = (d_state == ACK) & ~d_err;
  assign wb_dat_o    = d_rdat;
  assign wb_inst_ack = (i_state == ACK) & ~i_err;
  assign wb_inst_o   = i_rdat;
`ifdef WB_RESP_ERR_EN
  assign wb_err = ((d_state == ACK) & d_err) | ((i_state == ACK) & i_err);
`endif

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: vector table, hand-written corner sequences and a randomized
// run against an array-based memory model. Works with or without WB_RESP_ERR_EN.
module tb_wb_mem_responder;
  localparam int DATA_W = 32;
  localparam int PC_W   = 16;
  localparam int ADDR_W = 10;
  localparam int WS     = 1;
  localparam int LAT    = WS + 1;
  localparam int BOUND  = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_cyc, wb_stb, wb_we;
  logic [DATA_W-1:0] wb_adr, wb_dat_i, wb_dat_o;
  logic              wb_ack;
  logic              wb_inst_cyc, wb_inst_stb;
  logic [PC_W-1:0]   wb_inst_pc;
  logic [DATA_W-1:0] wb_inst_o;
  logic              wb_inst_ack;
  logic              err_w;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_mem_responder #(.DATA_W(DATA_W), .PC_W(PC_W), .ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .wb_inst_cyc(wb_inst_cyc), .wb_inst_stb(wb_inst_stb), .wb_inst_pc(wb_inst_pc),
    .wb_inst_o(wb_inst_o), .wb_inst_ack(wb_inst_ack)
`ifdef WB_RESP_ERR_EN
    , .wb_err(err_w)
`endif
  );
`ifndef WB_RESP_ERR_EN
  assign err_w = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starts right after a negedge; returns the ack/err latency in cycles (0 = timed out).
  task automatic xfer(input bit inst, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      output logic [31:0] rd, output int lat, output bit err);
    if (inst) begin
      wb_inst_cyc = 1'b1; wb_inst_stb = 1'b1; wb_inst_pc = adr[PC_W-1:0];
    end else begin
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
    end
    lat = 0; rd = '0; err = 1'b0;
    for (int k = 1; k <= BOUND; k++) begin
      @(negedge clk);
      if (inst ? wb_inst_ack : wb_ack) begin
        lat = k; rd = inst ? wb_inst_o : wb_dat_o; break;
      end
      if (err_w) begin
        lat = k; err = 1'b1; rd = inst ? wb_inst_o : wb_dat_o; break;
      end
      chk("dout_zero_outside_ack", inst ? wb_inst_o : wb_dat_o, '0);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_inst_cyc = 1'b0; wb_inst_stb = 1'b0;
    @(negedge clk);
    chk("ack_single_pulse", {30'd0, wb_ack, wb_inst_ack}, '0);
  endtask

  typedef struct {
    bit          inst;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp;
    bit          exp_err;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  bit          ref_vld [0:(1<<ADDR_W)-1];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    bit          err;
    logic [5:0]  pat;

    rst = 1'b0;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_dat_i = '0;
    wb_inst_cyc = 0; wb_inst_stb = 0; wb_inst_pc = '0;
    repeat (2) @(negedge clk);
    chk("reset_ack", wb_ack, 0);
    chk("reset_inst_ack", wb_inst_ack, 0);
    chk("reset_dat_o", wb_dat_o, 0);
    chk("reset_inst_o", wb_inst_o, 0);
    chk("reset_err", err_w, 0);
    rst = 1'b1;
    @(negedge clk);

    // --- vector table ---
    tbl.push_back('{0, 1, 32'h5,   32'hDEADBEEF, 32'h0,        0});
    tbl.push_back('{0, 0, 32'h5,   32'h0,        32'hDEADBEEF, 0});
    tbl.push_back('{0, 1, 32'h3FF, 32'h12345678, 32'h0,        0});
    tbl.push_back('{1, 0, 32'h3FF, 32'h0,        32'h12345678, 0});
    tbl.push_back('{0, 1, 32'h3,   32'h22,       32'h0,        0});
    tbl.push_back('{1, 0, 32'h5,   32'h0,        32'hDEADBEEF, 0});
    tbl.push_back('{0, 0, 32'h3,   32'h0,        32'h22,       0});
`ifdef WB_RESP_ERR_EN
    tbl.push_back('{0, 0, 32'h400, 32'h0,        32'h0,        1});
    tbl.push_back('{0, 1, 32'h405, 32'hBAD0BAD0, 32'h0,        1});
    tbl.push_back('{1, 0, 32'h7FF, 32'h0,        32'h0,        1});
    tbl.push_back('{0, 0, 32'h5,   32'h0,        32'hDEADBEEF, 0});
`else
    tbl.push_back('{0, 0, 32'h405, 32'h0,        32'hDEADBEEF, 0});
    tbl.push_back('{1, 0, 32'h7FF, 32'h0,        32'h12345678, 0});
`endif
    foreach (tbl[i]) begin
      xfer(tbl[i].inst, tbl[i].we, tbl[i].adr, tbl[i].dat, rd, lat, err);
      chk($sformatf("tbl%0d_latency", i), lat, LAT);
      if (!tbl[i].we || tbl[i].exp_err) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
`ifdef WB_RESP_ERR_EN
      chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
`endif
    end

    // --- abort: drop cyc during WAIT, write must not land ---
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h3; wb_dat_i = 32'h11;
    @(negedge clk);
    chk("abort_ack_wait", wb_ack, 0);
    wb_cyc = 0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_ack", wb_ack, 0);
    end
    wb_stb = 0; wb_we = 0;
    xfer(0, 0, 32'h3, 0, rd, lat, err);
    chk("abort_readback", rd, 32'h22);

    // --- concurrent ports, same address: fetch sees the old word ---
    xfer(0, 1, 32'h7, 32'h0BADF00D, rd, lat, err);
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h7; wb_dat_i = 32'hA5A5A5A5;
    wb_inst_cyc = 1; wb_inst_stb = 1; wb_inst_pc = 16'h7;
    @(negedge clk);
    chk("conc_acks_early", {wb_ack, wb_inst_ack}, 0);
    @(negedge clk);
    chk("conc_both_acks", {wb_ack, wb_inst_ack}, 2'b11);
    chk("conc_old_word", wb_inst_o, 32'h0BADF00D);
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_inst_cyc = 0; wb_inst_stb = 0;
    @(negedge clk);
    xfer(1, 0, 32'h7, 0, rd, lat, err);
    chk("conc_new_word", rd, 32'hA5A5A5A5);

    // --- back-to-back: held request gives acks every WS+2 cycles ---
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h5;
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pat[k] = wb_ack;
      if (wb_ack) chk("b2b_rdata", wb_dat_o, 32'hDEADBEEF);
    end
    wb_cyc = 0; wb_stb = 0;
    chk("b2b_ack_pattern", pat, 6'b010010);
    @(negedge clk);

    // --- reset during a data WAIT while the fetch is in ACK ---
    xfer(0, 1, 32'h9, 32'h55, rd, lat, err);
    xfer(0, 1, 32'hB, 32'h77, rd, lat, err);
    wb_inst_cyc = 1; wb_inst_stb = 1; wb_inst_pc = 16'hB;
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h9; wb_dat_i = 32'h99;
    @(negedge clk);
    chk("rst_pre_inst_ack", wb_inst_ack, 1);
    chk("rst_pre_inst_o", wb_inst_o, 32'h77);
    rst = 1'b0;
    #1;
    chk("rst_async_outputs", {wb_ack, wb_inst_ack, err_w}, 0);
    chk("rst_async_inst_o", wb_inst_o, 0);
    chk("rst_async_dat_o", wb_dat_o, 0);
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_inst_cyc = 0; wb_inst_stb = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(0, 0, 32'h9, 0, rd, lat, err);
    chk("rst_fresh_latency", lat, LAT);
    chk("rst_no_write", rd, 32'h55);

    // --- randomized run against the array model ---
    foreach (ref_vld[i]) ref_vld[i] = 1'b0;
    for (int n = 0; n < 300; n++) begin
      bit          inst, we, oor, abort;
      int          idx;
      logic [31:0] adr, dat;
      inst  = ($urandom % 2) == 1;
      we    = !inst && (($urandom % 2) == 1);
      idx   = $urandom % 16;
      oor   = ($urandom % 8) == 0;
      adr   = 32'(idx);
      if (oor) adr[ADDR_W + $urandom_range(0, 5)] = 1'b1;
      dat   = $urandom;
      abort = we && (($urandom % 8) == 0);
      if (abort) begin
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = adr; wb_dat_i = dat;
        @(negedge clk);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        repeat (2) begin
          @(negedge clk);
          chk("rand_abort_no_ack", wb_ack, 0);
        end
        continue;
      end
      xfer(inst, we, adr, dat, rd, lat, err);
      chk("rand_latency", lat, LAT);
`ifdef WB_RESP_ERR_EN
      chk("rand_err", err, oor);
      if (oor) begin
        chk("rand_err_rdata", rd, 0);
        continue;
      end
`endif
      if (we) begin
        ref_mem[idx] = dat;
        ref_vld[idx] = 1'b1;
      end else if (ref_vld[idx]) begin
        chk("rand_rdata", rd, ref_mem[idx]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
